ps2_kbd_ctrl: RTL and testbench
===============================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 8, scan-byte FIFO entries (power of 2, >=2).
REQ-002 SHALL provide parameter CNT_W, default 8, press counter width (>=8).
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-007 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-008 SHALL have port key_code  output  8  last make code accepted.
REQ-009 SHALL have port key_ext  output  1  key_code was E0-prefixed.
REQ-010 SHALL have port key_down  output  1  key_code/key_ext currently held.
REQ-011 SHALL have port press_count  output  CNT_W  count of new key presses.
REQ-012 SHALL have port overflow  output  1  sticky: a received byte was dropped on a full FIFO.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse per rejected frame.
REQ-014 SHALL have port o_seg  output  32  four 7-seg digits; o_seg[7:0]=digit0 ... o_seg[31:24]=digit3.

Function
REQ-015 SHALL synchronise ps2_clk and ps2_data through 2 flops each and detect the ps2_clk falling edge with a third ps2_clk flop.
REQ-016 SHALL sample ps2_data on each detected falling edge into an 11-bit frame: start, 8 data LSB first, parity, stop.
REQ-017 SHALL accept a frame only if start=0, stop=1 and the 8 data bits plus parity hold an odd number of ones.
REQ-018 SHALL push an accepted byte into the FIFO in the cycle after the stop-bit edge is detected.
REQ-019 SHALL discard a rejected frame without a FIFO push and pulse frame_err high for exactly one cycle in that same push cycle.
REQ-020 SHALL clear the bit counter, with no push and no frame_err, when TIMEOUT_CYC cycles pass with the bit counter nonzero and no falling edge.
REQ-021 SHALL, when the FIFO is full and no pop occurs that cycle, drop the new byte and set overflow, which stays 1 until reset.
REQ-022 SHALL accept a push to a full FIFO when a pop occurs in the same cycle, with no overflow.
REQ-023 SHALL pop one byte per cycle whenever the FIFO is non-empty; decode FSM and outputs update at the clock edge that performs the pop.
REQ-024 SHALL implement decode FSM states IDLE, EXT, BRK, EXT_BRK.
REQ-025 IDLE: E0 -> EXT; F0 -> BRK; any other byte b is a make with ext=0, FSM stays IDLE.
REQ-026 EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte b is a make with ext=1, then -> IDLE.
REQ-027 BRK or EXT_BRK: any byte b is a break with ext=0 or 1 respectively, then -> IDLE.
REQ-028 Make(b,ext): key_code<=b, key_ext<=ext, key_down<=1; press_count increments only if the old state was not key_down=1 with the same code and ext, so typematic repeats are not counted.
REQ-029 Break(b,ext): key_down<=0 only if b==key_code and ext==key_ext; otherwise no output change.
REQ-030 press_count SHALL wrap modulo 2^CNT_W.
REQ-031 Digits SHALL be active-low with segments a..g = bits 0..6 and bit 7 = dp, always 1; hex glyphs include 0=C0, 1=F9, C=C6.
REQ-032 Digit0/1 SHALL show key_code[3:0]/[7:4] when key_down=1, and 8'hFF (blank) when key_down=0.
REQ-033 Digit2/3 SHALL always show press_count[3:0]/[7:4]; o_seg SHALL be a combinational decode of registered state.

Reset
REQ-034 resetn=0 SHALL immediately clear synchronisers, bit counter, timeout counter, FIFO pointers, FSM (IDLE), key_code=0, key_ext=0, key_down=0, press_count=0, overflow=0, frame_err=0, giving o_seg=32'hC0C0_FFFF.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL be received correctly.

Verification
V1: frame 1C, valid odd parity -> push; key_code=1C, key_down=1, press_count=1, o_seg=32'hC0F9_F9C6.
V2: 1C, 1C, 1C (typematic) then F0 1C -> press_count stays 1; after F0 1C, key_down=0 and digits 0/1 = FF.
V3: E0 75 then E0 F0 75 -> key_ext=1, key_code=75, key_down 1 then 0; press_count=1.
V4: frame 1C with parity bit flipped, then a frame with stop=0 -> two one-cycle frame_err pulses, no FIFO push, outputs unchanged.
V5: pop stalled by force, FIFO_DEPTH+1 frames sent -> overflow=1 and stays 1; with a pop in the same cycle as a push on full, no overflow.
V6: 5 bits sent, then idle > TIMEOUT_CYC, then full frame 1C -> no frame_err, key_code=1C; separately, resetn pulse mid-frame -> o_seg=32'hC0C0_FFFF and the next frame decodes.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl
//   PS/2 keyboard receiver: synchronises the raw PS/2 lines, assembles
//   11-bit frames, queues accepted scan bytes in a small FIFO and decodes
//   them (E0 extended prefix, F0 break prefix) into the last key pressed,
//   its held state and a press counter, shown on four 7-segment digits.
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   ps2_clk     raw PS/2 clock (asynchronous)
//   ps2_data    raw PS/2 data (asynchronous)
//   key_code    last make code accepted
//   key_ext     key_code was E0-prefixed
//   key_down    key_code/key_ext currently held
//   press_count count of new key presses (wraps)
//   overflow    sticky: a received byte was dropped on a full FIFO
//   frame_err   one-cycle pulse per rejected frame
//   o_seg       four active-low digits, o_seg[7:0] = digit0 ... [31:24] = digit3
module ps2_kbd_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] press_count,
    output logic             overflow,
    output logic             frame_err,
    output logic [31:0]      o_seg
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    // ------------------------------------------------------------------
    // Synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic       fall;
    logic       ps2_bit;

    assign fall    = clk_sync[2] & ~clk_sync[1];
    assign ps2_bit = data_sync[1];

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;     // start, data[7:0], parity once ten bits are in
    logic [TW-1:0] to_cnt;
    logic          stop_edge;
    logic          frame_ok;
    logic          push;

    assign stop_edge = fall && (bit_cnt == 4'd10);
    // current ps2_bit is the stop bit; data plus parity must hold odd ones
    assign frame_ok  = ~shift[0] & ps2_bit & (^shift[9:1]);
    assign push      = stop_edge & frame_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync  <= '0;
            data_sync <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            frame_err <= stop_edge & ~frame_ok;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= {ps2_bit, shift[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-byte FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic [7:0]  rd_byte;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = ~empty;
    // a pop in the same cycle frees the slot being written
    assign wr_en   = push & (~full | pop);
    assign rd_byte = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= shift[8:1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nx;
    logic [7:0]       code_nx;
    logic             ext_nx;
    logic             down_nx;
    logic [CNT_W-1:0] count_nx;
    logic             make_ev;
    logic             break_ev;
    logic             ev_ext;

    always_comb begin
        state_nx = state;
        make_ev  = 1'b0;
        break_ev = 1'b0;
        ev_ext   = 1'b0;
        if (pop) begin
            unique case (state)
                IDLE: begin
                    if (rd_byte == 8'hE0)      state_nx = EXT;
                    else if (rd_byte == 8'hF0) state_nx = BRK;
                    else                       make_ev  = 1'b1;
                end
                EXT: begin
                    if (rd_byte == 8'hF0) begin
                        state_nx = EXT_BRK;
                    end else if (rd_byte != 8'hE0) begin
                        make_ev  = 1'b1;
                        ev_ext   = 1'b1;
                        state_nx = IDLE;
                    end
                end
                BRK: begin
                    break_ev = 1'b1;
                    state_nx = IDLE;
                end
                EXT_BRK: begin
                    break_ev = 1'b1;
                    ev_ext   = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        code_nx  = key_code;
        ext_nx   = key_ext;
        down_nx  = key_down;
        count_nx = press_count;
        if (make_ev) begin
            code_nx = rd_byte;
            ext_nx  = ev_ext;
            down_nx = 1'b1;
            // typematic repeat of the held key is not a new press
            if (!(key_down && key_code == rd_byte && key_ext == ev_ext)) begin
                count_nx = press_count + CNT_W'(1);
            end
        end else if (break_ev) begin
            if (rd_byte == key_code && ev_ext == key_ext) begin
                down_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_down    <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nx;
            key_code    <= code_nx;
            key_ext     <= ext_nx;
            key_down    <= down_nx;
            press_count <= count_nx;
        end
    end

    // ------------------------------------------------------------------
    // 7-segment display (active low, dp off)
    // ------------------------------------------------------------------
    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] g;
        unique case (n)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign o_seg = {hex7(press_count[7:4]),
                    hex7(press_count[3:0]),
                    key_down ? hex7(key_code[7:4]) : 8'hFF,
                    key_down ? hex7(key_code[3:0]) : 8'hFF};

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Testbench for ps2_kbd_ctrl: randomized PS/2 frames checked against a
// behavioural key-decoding model, plus directed literal expectations.
module tb_ps2_kbd_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned TO    = 100;
    localparam int unsigned HALF  = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_down;
    logic [CW-1:0] press_count;
    logic          overflow;
    logic          frame_err;
    logic [31:0]   o_seg;

    ps2_kbd_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .press_count(press_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .o_seg      (o_seg)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_code;
    logic       m_ext;
    logic       m_down;
    logic [7:0] m_cnt;
    logic       m_ovf;
    bit         pend_ext;
    bit         pend_brk;
    bit         stalled;
    int         m_ferr_exp = 0;
    int         ferr_cnt   = 0;
    logic [7:0] m_q[$];
    bit         chk = 0;

    logic [7:0] gly [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic void model_reset();
        m_code = 8'h00; m_ext = 1'b0; m_down = 1'b0; m_cnt = 8'h00; m_ovf = 1'b0;
        pend_ext = 0; pend_brk = 0; m_q.delete();
    endfunction

    // Scan-set-2 interpretation of one byte from the keyboard stream.
    function automatic void model_decode(input logic [7:0] b);
        if (pend_brk) begin
            if (b == m_code && logic'(pend_ext) == m_ext) m_down = 1'b0;
            pend_brk = 0;
            pend_ext = 0;
        end else if (b == 8'hE0) begin
            pend_ext = 1;
        end else if (b == 8'hF0) begin
            pend_brk = 1;
        end else begin
            if (!(m_down && m_code == b && m_ext == logic'(pend_ext))) m_cnt = m_cnt + 8'd1;
            m_code = b;
            m_ext  = logic'(pend_ext);
            m_down = 1'b1;
            pend_ext = 0;
        end
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (!stalled)                model_decode(b);
        else if (m_q.size() < DEPTH) m_q.push_back(b);
        else                         m_ovf = 1'b1;
    endfunction

    function automatic void model_drain();
        while (m_q.size() > 0) model_decode(m_q.pop_front());
    endfunction

    function automatic logic [31:0] exp_seg();
        return {gly[m_cnt[7:4]], gly[m_cnt[3:0]],
                m_down ? gly[m_code[7:4]] : 8'hFF,
                m_down ? gly[m_code[3:0]] : 8'hFF};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (resetn && frame_err) ferr_cnt++;
        if (chk) begin
            cmp("key_code",    32'(key_code),    32'(m_code));
            cmp("key_ext",     32'(key_ext),     32'(m_ext));
            cmp("key_down",    32'(key_down),    32'(m_down));
            cmp("press_count", 32'(press_count), 32'(m_cnt));
            cmp("overflow",    32'(overflow),    32'(m_ovf));
            cmp("frame_err",   32'(frame_err),   32'd0);
            cmp("o_seg",       o_seg,            exp_seg());
            cmp("ferr_count",  32'(ferr_cnt),    32'(m_ferr_exp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic ps2_bit(input logic b);
        @(posedge clk); #1;
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // kind: 0 valid, 1 parity flipped, 2 stop=0, 3 start=1
    task automatic frame_head(input logic [7:0] b, input int kind);
        logic par;
        par = ~(^b);
        if (kind == 1) par = ~par;
        ps2_bit(kind == 3);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind);
        frame_head(b, kind);
        chk = 0;
        ps2_bit(kind != 2);
        repeat (4) @(posedge clk);
        if (kind == 0) model_push(b);
        else           m_ferr_exp++;
        #1 chk = 1;
        repeat (3) @(posedge clk);
    endtask

    logic [7:0] pool [8] = '{8'h1C, 8'h1C, 8'h75, 8'h32, 8'hE0, 8'hF0, 8'hF0, 8'h5A};
    logic [7:0] fill [6] = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D, 8'h2C};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         k;
        bit         seen;
        model_reset();
        stalled = 0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        cmp("reset_o_seg_literal", o_seg, 32'hC0C0_FFFF);
        #1 chk = 1;

        // single make
        send_frame(8'h1C, 0);
        cmp("v1_o_seg_literal", o_seg, 32'hC0F9_F9C6);
        cmp("v1_count_literal", 32'(press_count), 32'd1);

        // typematic repeats then break
        send_frame(8'h1C, 0);
        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        cmp("v2_count_literal", 32'(press_count), 32'd1);
        cmp("v2_digits_blank",  32'(o_seg[15:0]), 32'h0000_FFFF);

        // extended make / break
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        cmp("v3_make_literal", {23'd0, key_ext, key_code, key_down}, {23'd0, 1'b1, 8'h75, 1'b1});
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        cmp("v3_break_literal", {24'd0, key_ext, key_down, press_count[5:0]}, {24'd0, 1'b1, 1'b0, 6'd2});

        // rejected frames
        send_frame(8'h1C, 1);
        send_frame(8'h1C, 2);
        cmp("v4_ferr_literal", 32'(ferr_cnt), 32'd2);
        cmp("v4_code_literal", 32'(key_code), 32'h75);

        // partial frame abandoned by timeout
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        repeat (TO + 20) @(posedge clk);
        send_frame(8'h1C, 0);
        cmp("v6_timeout_code_literal", 32'(key_code), 32'h1C);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            b = pool[$urandom_range(0, 7)];
            k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(b, k);
        end

        // counter wrap: alternating keys, every one a new press
        for (int i = 0; i < 260; i++) send_frame((i % 2 == 0) ? 8'h1C : 8'h32, 0);

        // full FIFO with push and pop in the same cycle: no overflow
        force dut.pop = 1'b0;
        stalled = 1;
        for (int i = 0; i < DEPTH; i++) send_frame(fill[i], 0);
        frame_head(8'h3C, 0);
        chk = 0;
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dut.fall && dut.bit_cnt == 4'd10) seen = 1;
        end
        release dut.pop;
        cmp("simul_push_pop_seen", 32'(seen), 32'd1);
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (DEPTH + 6) @(posedge clk);
        stalled = 0;
        model_drain();
        model_decode(8'h3C);
        #1 chk = 1;
        repeat (3) @(posedge clk);
        cmp("simul_no_overflow_literal", 32'(overflow), 32'd0);

        // stalled FIFO overflow
        force dut.pop = 1'b0;
        stalled = 1;
        for (int i = 0; i < DEPTH + 1; i++) send_frame(fill[i+1], 0);
        cmp("v5_overflow_literal", 32'(overflow), 32'd1);
        chk = 0;
        @(posedge clk); #1;
        release dut.pop;
        repeat (DEPTH + 4) @(posedge clk);
        stalled = 0;
        model_drain();
        #1 chk = 1;
        send_frame(8'h1C, 0);
        cmp("v5_overflow_sticky", 32'(overflow), 32'd1);

        // reset in the middle of a frame
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        chk = 0;
        @(posedge clk); #1 resetn = 1'b0;
        #3;
        cmp("v6_reset_o_seg_literal", o_seg, 32'hC0C0_FFFF);
        cmp("v6_reset_flags_literal", {30'd0, overflow, key_down}, 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk = 1;
        send_frame(8'h32, 0);
        cmp("v6_after_reset_literal", {16'd0, key_code, press_count}, {16'd0, 8'h32, 8'd1});

        repeat (5) @(posedge clk);
        chk = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
